// File: rtl/matrix_pkg.sv
// Shared types and constants for the complex 2x2 matrix-multiply sequencer.
// Q1.35 signed fixed point, 37-bit words, 40-bit accumulators.
package matrix_pkg;

  localparam int WIDTH  = 37;
  localparam int FRAC   = 35;
  localparam int NBYTES = 5;
  localparam int ACCW   = WIDTH + 3;
  localparam int SHW    = 8 * (NBYTES - 1);

  typedef logic signed [WIDTH-1:0] word_t;
  typedef logic signed [ACCW-1:0]  acc_t;

  typedef struct packed {
    word_t re;
    word_t im;
  } cplx_t;

  typedef cplx_t [1:0][1:0] mtx2_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPUTE,
    SEND
  } state_t;

  localparam word_t Q_ONE = 37'sh0800000000;
  localparam word_t Q_MAX = 37'sh0FFFFFFFFF;
  localparam word_t Q_MIN = 37'sh1000000000;

  localparam acc_t ACC_MAX = 40'sh0FFFFFFFFF;
  localparam acc_t ACC_MIN = 40'shF000000000;

  localparam logic [2:0] LAST_BYTE = 3'(NBYTES - 1);

  function automatic word_t sat(input acc_t v);
    word_t r;
    if (v > ACC_MAX)
      r = Q_MAX;
    else if (v < ACC_MIN)
      r = Q_MIN;
    else
      r = v[WIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/matrix_mult_sequencer_mac.sv
// Single shared signed multiplier with re/im accumulators.
// Outputs show the saturated value the accumulators will hold after this cycle.
module fixed_mac
  import matrix_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  clr,
  input  logic  sub,
  input  logic  sel_im,
  input  word_t a,
  input  word_t b,
  output word_t sat_re,
  output word_t sat_im
);

  logic signed [2*WIDTH-1:0] prod;
  acc_t term;
  acc_t acc_re;
  acc_t acc_im;
  acc_t nx_re;
  acc_t nx_im;
  acc_t sum;

  assign prod = a * b;

  // floor shift: keep the top bits and sign-extend into the accumulator
  assign term = {
    {(ACCW - (2*WIDTH - FRAC)){prod[2*WIDTH-1]}},
    prod[2*WIDTH-1:FRAC]
  };

  always_comb begin
    sum   = sel_im ? acc_im : acc_re;
    sum   = sub ? sum - term : sum + term;
    nx_re = acc_re;
    nx_im = acc_im;
    if (en && !sel_im)
      nx_re = sum;
    if (en && sel_im)
      nx_im = sum;
  end

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      acc_re <= '0;
      acc_im <= '0;
    end else begin
      acc_re <= nx_re;
      acc_im <= nx_im;
    end
  end

  assign sat_re = sat(nx_re);
  assign sat_im = sat(nx_im);

endmodule

// File: rtl/matrix_mult_sequencer.sv
// Loads two complex 2x2 matrices from UART bytes, multiplies them
// through one shared MAC and streams the product back out.
module matrix_mult_sequencer
  import matrix_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] received_byte,
  input  logic       received_ready,
  output logic [7:0] transmit_byte,
  output logic       transmit_ready,
  input  logic       transmit_available,
  output logic       busy,
  output logic       done
);

  state_t state;
  state_t state_nx;

  logic [2:0]     byte_cnt;
  logic [2:0]     word_idx;
  logic [4:0]     cyc;
  logic [SHW-1:0] shreg;

  mtx2_t a_m;
  mtx2_t b_m;
  mtx2_t c_m;

  logic  strobe_ld;
  logic  word_done;
  logic  last_word;
  logic  consume;
  logic  last_byte;
  word_t new_word;

  logic  mac_en;
  logic  mac_clr;
  logic  mac_sub;
  logic  mac_im;
  logic  c_wr;
  cplx_t ae;
  cplx_t be;
  word_t mul_a;
  word_t mul_b;
  word_t sat_re;
  word_t sat_im;

  cplx_t              tx_c;
  word_t              tx_w;
  logic [8*NBYTES-1:0] tx_ext;

  assign strobe_ld = received_ready &&
                     (state == LOAD_A || state == LOAD_B);
  assign word_done = strobe_ld && byte_cnt == LAST_BYTE;
  assign last_word = word_done && word_idx == 3'd7;
  assign consume   = transmit_ready && transmit_available;
  assign last_byte = consume && byte_cnt == LAST_BYTE &&
                     word_idx == 3'd7;

  // bits above WIDTH-1 in the final byte are dropped here
  assign new_word = {
    received_byte[WIDTH-SHW-1:0],
    shreg
  };

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    busy           = 1'b1;
    transmit_ready = 1'b0;
    transmit_byte  = 8'h00;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          state_nx = LOAD_A;
      end
      LOAD_A:
        if (last_word)
          state_nx = LOAD_B;
      LOAD_B:
        if (last_word)
          state_nx = COMPUTE;
      COMPUTE:
        if (cyc == 5'd31)
          state_nx = SEND;
      SEND: begin
        transmit_ready = 1'b1;
        transmit_byte  = tx_ext[{byte_cnt, 3'b000} +: 8];
        if (last_byte)
          state_nx = IDLE;
      end
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      byte_cnt <= '0;
      word_idx <= '0;
      cyc      <= '0;
      shreg    <= '0;
      done     <= 1'b0;
    end else begin
      done <= last_byte;
      if (strobe_ld)
        shreg <= {received_byte, shreg[SHW-1:8]};
      if (state != state_nx) begin
        byte_cnt <= '0;
        word_idx <= '0;
        cyc      <= '0;
      end else begin
        if (state == COMPUTE)
          cyc <= cyc + 5'd1;
        if (strobe_ld || consume) begin
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt <= '0;
            word_idx <= word_idx + 3'd1;
          end else begin
            byte_cnt <= byte_cnt + 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && word_done) begin
      if (state == LOAD_A) begin
        if (word_idx[0])
          a_m[word_idx[2]][word_idx[1]].im <= new_word;
        else
          a_m[word_idx[2]][word_idx[1]].re <= new_word;
      end else begin
        if (word_idx[0])
          b_m[word_idx[2]][word_idx[1]].im <= new_word;
        else
          b_m[word_idx[2]][word_idx[1]].re <= new_word;
      end
    end
    if (reset && c_wr)
      c_m[cyc[4]][cyc[3]] <= {sat_re, sat_im};
  end

  // cyc = {i, j, k, product}; product order re+, re-, im+, im+
  always_comb begin
    ae      = a_m[cyc[4]][cyc[2]];
    be      = b_m[cyc[2]][cyc[3]];
    mul_a   = cyc[0] ? ae.im : ae.re;
    mul_b   = (cyc[0] ^ cyc[1]) ? be.im : be.re;
    mac_sub = cyc[1:0] == 2'd1;
    mac_im  = cyc[1];
    mac_en  = state == COMPUTE;
    c_wr    = mac_en && cyc[2:0] == 3'd7;
    mac_clr = !mac_en || c_wr;
  end

  fixed_mac u_mac (
    .clk    (clk),
    .reset  (reset),
    .en     (mac_en),
    .clr    (mac_clr),
    .sub    (mac_sub),
    .sel_im (mac_im),
    .a      (mul_a),
    .b      (mul_b),
    .sat_re (sat_re),
    .sat_im (sat_im)
  );

  always_comb begin
    tx_c   = c_m[word_idx[2]][word_idx[1]];
    tx_w   = word_idx[0] ? tx_c.im : tx_c.re;
    tx_ext = {{(8*NBYTES-WIDTH){tx_w[WIDTH-1]}}, tx_w};
  end

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Scoreboard bench for matrix_mult_sequencer: expected result bytes are
// queued when operands are loaded and popped as the DUT transmits.
module tb_matrix_mult_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] received_byte = 8'h00;
  logic       received_ready = 1'b0;
  logic       transmit_available = 1'b0;
  logic [7:0] transmit_byte;
  logic       transmit_ready;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  logic [7:0]        exp_q[$];
  logic [7:0]        rxb[40];
  logic signed [36:0] ta[8];
  logic signed [36:0] tbm[8];
  logic signed [36:0] cw[8];
  logic signed [36:0] rx[8];

  localparam logic signed [36:0] ONE  = 37'sd34359738368;
  localparam logic signed [36:0] ONEH = 37'sd51539607552;
  localparam logic signed [36:0] SMAX = 37'sd68719476735;
  localparam logic signed [36:0] SMIN = -37'sd68719476736;

  always #5 clk = ~clk;

  always @(negedge clk)
    if (done === 1'b1)
      done_cnt++;

  matrix_mult_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .received_byte      (received_byte),
    .received_ready     (received_ready),
    .transmit_byte      (transmit_byte),
    .transmit_ready     (transmit_ready),
    .transmit_available (transmit_available),
    .busy               (busy),
    .done               (done)
  );

  function automatic logic signed [79:0] mul(
    input logic signed [36:0] a,
    input logic signed [36:0] b
  );
    logic signed [79:0] ae;
    logic signed [79:0] be;
    logic signed [79:0] p;
    ae = a;
    be = b;
    p  = ae * be;
    return p >>> 35;
  endfunction

  function automatic logic signed [36:0] satm(input logic signed [79:0] v);
    if (v > 80'sd68719476735)
      return SMAX;
    if (v < -80'sd68719476736)
      return SMIN;
    return v[36:0];
  endfunction

  task automatic model();
    logic signed [79:0] re;
    logic signed [79:0] im;
    logic signed [36:0] ar, ai, br, bi;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        re = 0;
        im = 0;
        for (int k = 0; k < 2; k++) begin
          ar = ta[i*4+k*2];
          ai = ta[i*4+k*2+1];
          br = tbm[k*4+j*2];
          bi = tbm[k*4+j*2+1];
          re = re + mul(ar, br) - mul(ai, bi);
          im = im + mul(ar, bi) + mul(ai, br);
        end
        cw[i*4+j*2]   = satm(re);
        cw[i*4+j*2+1] = satm(im);
      end
  endtask

  task automatic push_expected();
    logic [39:0] e;
    for (int w = 0; w < 8; w++) begin
      e = {{3{cw[w][36]}}, cw[w]};
      for (int b = 0; b < 5; b++)
        exp_q.push_back(e[b*8 +: 8]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    received_byte  = b;
    received_ready = 1'b1;
    @(negedge clk);
    received_ready = 1'b0;
  endtask

  // junk in the top three bits must be discarded by the loader
  task automatic send_word(input logic signed [36:0] w);
    logic [39:0] e;
    e = {3'b101, w};
    for (int b = 0; b < 5; b++)
      send_byte(e[b*8 +: 8]);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_ops(input bit prot);
    for (int w = 0; w < 8; w++) begin
      send_word(ta[w]);
      if (prot && w == 2)
        pulse_start();
    end
    for (int w = 0; w < 8; w++)
      send_word(tbm[w]);
  endtask

  // mode 0: always ready; 1: random backpressure plus a 100-cycle stall;
  // 2: stray received_ready strobe during SEND
  task automatic collect(input int n, input int mode);
    int got;
    int cyc;
    bit stalled;
    logic [7:0] e;
    logic [7:0] held;
    got = 0;
    cyc = 0;
    stalled = 0;
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      received_ready = 1'b0;
      if (mode == 1 && got == 10 && !stalled && transmit_ready) begin
        stalled = 1;
        transmit_available = 1'b0;
        held = transmit_byte;
        repeat (100) @(negedge clk);
        checks++;
        if (transmit_ready !== 1'b1 || transmit_byte !== held) begin
          errors++;
          $display("FAIL stall_hold: ready=%b byte=%h want ready=1 byte=%h",
                   transmit_ready, transmit_byte, held);
        end
      end
      transmit_available = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2 && got == 7) begin
        received_byte  = 8'hA5;
        received_ready = 1'b1;
      end
      if (transmit_ready === 1'b1 && transmit_available) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: got %h with empty scoreboard",
                   transmit_byte);
        end else begin
          e = exp_q.pop_front();
          if (transmit_byte !== e) begin
            errors++;
            $display("FAIL tx_byte[%0d]: got %h want %h", got,
                     transmit_byte, e);
          end
        end
        rxb[got] = transmit_byte;
        got++;
      end
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL tx_timeout: got %0d bytes want %0d", got, n);
    end
    @(posedge clk);
    #1;
    transmit_available = 1'b0;
    received_ready = 1'b0;
    if (n == 40) begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || transmit_ready !== 1'b0) begin
        errors++;
        $display("FAIL end_state: done=%b busy=%b ready=%b want 1 0 0",
                 done, busy, transmit_ready);
      end
      for (int w = 0; w < 8; w++)
        rx[w] = {rxb[w*5+4][4:0], rxb[w*5+3], rxb[w*5+2],
                 rxb[w*5+1], rxb[w*5]};
    end
  endtask

  task automatic run_op(input int mode, input bit prot);
    int d0;
    model();
    if (prot)
      repeat (3) send_byte(8'h5A);
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start: got %b want 1", busy);
    end
    load_ops(prot);
    push_expected();
    d0 = done_cnt;
    collect(40, mode);
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL done_pulses: got %0d want 1", done_cnt - d0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d bytes unsent want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic clear_ops();
    for (int w = 0; w < 8; w++) begin
      ta[w]  = '0;
      tbm[w] = '0;
    end
  endtask

  task automatic set_identity();
    clear_ops();
    ta[0] = ONE;
    ta[6] = ONE;
    tbm[0] = 37'sd24296004000;
    tbm[2] = 37'sd24296004001;
    tbm[4] = 37'sd24296004002;
    tbm[6] = -37'sd24296004003;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (busy !== 1'b0 || transmit_ready !== 1'b0 ||
        transmit_byte !== 8'h00 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b ready=%b byte=%h done=%b want 0 0 00 0",
               tag, busy, transmit_ready, transmit_byte, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("idle_after_reset");
  endtask

  task automatic test_identity();
    set_identity();
    run_op(0, 0);
    for (int w = 0; w < 8; w++) begin
      checks++;
      if (rx[w] !== tbm[w]) begin
        errors++;
        $display("FAIL identity_c[%0d]: got %0d want %0d", w, rx[w], tbm[w]);
      end
    end
  endtask

  task automatic test_complex();
    clear_ops();
    ta[1]  = ONE;
    tbm[0] = ONE;
    run_op(0, 0);
    for (int w = 0; w < 8; w++) begin
      checks++;
      if (rx[w] !== ((w == 1) ? ONE : 37'sd0)) begin
        errors++;
        $display("FAIL complex_c[%0d]: got %0d want %0d", w, rx[w],
                 (w == 1) ? ONE : 37'sd0);
      end
    end
  endtask

  task automatic test_saturation();
    clear_ops();
    ta[0]  = ONEH;
    ta[2]  = ONEH;
    tbm[0] = ONEH;
    tbm[4] = ONEH;
    run_op(0, 0);
    checks++;
    if (rx[0] !== SMAX) begin
      errors++;
      $display("FAIL sat_pos: got %0d want %0d", rx[0], SMAX);
    end
    tbm[0] = -ONEH;
    tbm[4] = -ONEH;
    run_op(0, 0);
    checks++;
    if (rx[0] !== SMIN) begin
      errors++;
      $display("FAIL sat_neg: got %0d want %0d", rx[0], SMIN);
    end
  endtask

  task automatic test_backpressure();
    for (int w = 0; w < 8; w++) begin
      ta[w]  = 37'($urandom_range(0, 32'h7FFFFFFF)) - 37'sd1073741824;
      tbm[w] = 37'($urandom_range(0, 32'h7FFFFFFF)) <<< 3;
    end
    run_op(1, 0);
  endtask

  task automatic test_protocol();
    set_identity();
    ta[3] = -37'sd12345678901;
    run_op(2, 1);
  endtask

  task automatic test_reset_mid();
    set_identity();
    pulse_start();
    load_ops(0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_idle("reset_in_compute");
    repeat (50) @(negedge clk);
    check_idle("stays_idle_compute");
    pulse_start();
    load_ops(0);
    model();
    push_expected();
    collect(12, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_idle("reset_in_send");
    exp_q.delete();
    repeat (20) @(negedge clk);
    check_idle("stays_idle_send");
    test_identity();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_complex();
    test_saturation();
    test_backpressure();
    test_protocol();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_mult_sequencer.md
Name: matrix_mult_sequencer

Overview:
- Owns the shared complex 2x2 matrix-multiply datapath behind the coordinator's benchmark command ('B').
- After the coordinator decodes 'B' and pulses start, the block:
  - assembles two operand matrices from the UART byte stream;
  - schedules all 32 real products through one shared multiplier;
  - streams the 2x2 complex result back through the UART transmitter handshake.
- Values are signed fixed point Q1.35: 37 bits, 1.0 = 2^35 = 34359738368.

Parameters:
WIDTH, 37, operand/result word width in bits (signed)
FRAC, 35, fractional bits; product is arithmetic-shifted right by FRAC
NBYTES, 5, bytes per word on the wire = ceil(WIDTH/8), LSB first

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-low reset (reset==0 at a rising edge of clk resets the block)
start  in  1  one-cycle pulse from coordinator after 'B' byte; ignored unless IDLE
received_byte  in  8  byte from UART receiver
received_ready  in  1  received_byte valid this cycle (single-cycle strobe)
transmit_byte  out  8  byte to UART transmitter
transmit_ready  out  1  transmit_byte valid
transmit_available  in  1  transmitter can accept; byte consumed when transmit_ready && transmit_available
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when the last result byte is consumed

Behaviour:
- Reset: state=IDLE; transmit_ready=0, transmit_byte=0, busy=0, done=0; byte/word/element counters and accumulators cleared; operand storage need not be cleared.
- Reset mid-operation aborts immediately. A half-sent result is not resumed.
- Wire order (load and send): for row 0..1, col 0..1, part re then im. Each word is NBYTES bytes, LSB first.
  - On load, bits above WIDTH-1 in the last byte are discarded.
  - On send, the last byte carries sign-extension bits.
- IDLE: start=1 moves to LOAD_A. received_ready is ignored in IDLE and in every state other than LOAD_A/LOAD_B.
- LOAD_A: each received_ready strobe shifts one byte into the word assembler.
  - After 5 bytes, the word is written to A[row][col][part] and the word index increments.
  - After 8 words, go to LOAD_B.
- LOAD_B: same as LOAD_A; after 8 words, go to COMPUTE.
- COMPUTE: exactly 32 cycles, one real product per cycle.
  - For each element C[i][j] (row-major) and each k=0..1, four products in order:
    - re += Ar*Br
    - re -= Ai*Bi
    - im += Ar*Bi
    - im += Ai*Br
    where A=A[i][k], B=B[k][j].
  - Each product: 74-bit signed, arithmetic shift right FRAC (floor), sign-extended into a WIDTH+3 = 40-bit accumulator.
  - After the 8th product of an element, re and im are saturated to [-2^36, 2^36-1] and written to C. Accumulators then clear.
  - Operand select and accumulate are registered. C is complete on the cycle COMPUTE exits to SEND.
- SEND: presents 40 bytes in wire order.
  - transmit_ready=1 with transmit_byte stable until consumed.
  - On consume, advance to the next byte; transmit_ready stays high with no bubble.
  - transmit_available low stalls indefinitely without loss.
  - After the 40th byte is consumed: transmit_ready=0, done=1 for that one cycle, go to IDLE.
- start asserted while busy is ignored.
- received_ready coinciding with the LOAD_B to COMPUTE transition cannot occur (the transition follows a strobe). Any strobe during COMPUTE/SEND is dropped.

Decomposition:
- Shared package matrix_pkg:
  - WIDTH, FRAC, NBYTES;
  - typedef word_t (signed [WIDTH-1:0]);
  - cplx_t (struct re/im);
  - mtx2_t (cplx_t [2][2]);
  - state enum {IDLE, LOAD_A, LOAD_B, COMPUTE, SEND};
  - constants Q_ONE=2^35, Q_MAX, Q_MIN.
- One sub-module fixed_mac: one signed multiply, shift, add/subtract-select into the 40-bit accumulator, clear input, and a saturating output. The sequencer instantiates exactly one.

Test Plan:
- Identity x X: A = I (re diag 34359738368), B = {24296004000, 24296004001, 24296004002, -24296004003}, im 0 -> C equals B exactly; 40 bytes out, done pulses once.
- Complex mult: A[0][0]=i (im 34359738368), other A entries 0; B[0][0]=1.0 -> C[0][0]={re 0, im 34359738368}, all other C entries 0.
- Positive saturation: A row0 = {1.5, 1.5} (51539607552), B col0 = {1.5, 1.5} -> C[0][0].re = 68719476735. Negating B gives -68719476736.
- Backpressure: hold transmit_available=0 for 100 cycles mid-SEND, toggling -> no byte lost or duplicated; order matches wire order.
- Protocol robustness: start during LOAD_A ignored; received_ready strobes in IDLE and SEND ignored; byte count and result unchanged.
- Reset mid-operation: reset=0 for 1 cycle during COMPUTE and during SEND -> outputs return to reset values next cycle. A fresh start followed by the Identity operands gives correct results.
